// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in source-clock cycles,
// flags ratio/duty errors against EXP_DIV and raises stall when toggling stops.
`timescale 1ns/1ps
module clk_div_monitor #(
  parameter int CNT_W   = 8,
  parameter int EXP_DIV = 7,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic             duty_ok,
  output logic             stall,
  output logic [7:0]       err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] EXP_V   = CNT_W'(EXP_DIV);
  localparam logic [CNT_W-1:0] TO_V    = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    STALLED = 2'd2
  } state_t;

  state_t           state_r;
  logic             s1_r, s2_r, s3_r;
  logic             rise_s;
  logic [CNT_W-1:0] period_cnt_r, high_cnt_r;
  logic [CNT_W-1:0] period_nxt_s, high_nxt_s;
  logic             freq_s, duty_s;
  logic [7:0]       err_nxt_s;

  // |2*hi - per| <= 1, evaluated one bit wider so 2*hi cannot overflow.
  function automatic logic duty_within(input logic [CNT_W-1:0] per,
                                       input logic [CNT_W-1:0] hi);
    logic [CNT_W:0] twice, per_w, diff;
    twice = {hi, 1'b0};
    per_w = {1'b0, per};
    if (twice >= per_w) diff = twice - per_w;
    else                diff = per_w - twice;
    return (diff <= {{CNT_W{1'b0}}, 1'b1});
  endfunction

  // Two-flop synchronizer plus one delay flop for rise detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= div_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Next-count, classification and error-count arithmetic.
  always_comb begin
    rise_s = s2_r & ~s3_r;
    if (rise_s) begin
      period_nxt_s = CNT_ONE;
      high_nxt_s   = CNT_ONE;
    end else begin
      if (period_cnt_r == CNT_MAX) period_nxt_s = CNT_MAX;
      else                         period_nxt_s = period_cnt_r + CNT_ONE;
      if (!s2_r || high_cnt_r == CNT_MAX) high_nxt_s = high_cnt_r;
      else                                high_nxt_s = high_cnt_r + CNT_ONE;
    end
    freq_s = (period_cnt_r == EXP_V);
    duty_s = duty_within(period_cnt_r, high_cnt_r);
    if (freq_s && duty_s)       err_nxt_s = err_cnt;
    else if (err_cnt == 8'hFF)  err_nxt_s = err_cnt;
    else                        err_nxt_s = err_cnt + 8'd1;
  end

  // Free-running period and high-time counters, restarted on each rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_cnt_r <= {CNT_W{1'b0}};
      high_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      period_cnt_r <= period_nxt_s;
      high_cnt_r   <= high_nxt_s;
    end
  end

  // Measurement FSM with registered result, status and stall outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      period_out <= {CNT_W{1'b0}};
      high_out   <= {CNT_W{1'b0}};
      meas_valid <= 1'b0;
      freq_ok    <= 1'b0;
      duty_ok    <= 1'b0;
      stall      <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      meas_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rise_s) state_r <= ARMED;
        end
        ARMED: begin
          // A rise in the timeout cycle still counts as a valid measurement.
          if (rise_s) begin
            period_out <= period_cnt_r;
            high_out   <= high_cnt_r;
            meas_valid <= 1'b1;
            freq_ok    <= freq_s;
            duty_ok    <= duty_s;
            err_cnt    <= err_nxt_s;
          end else if (period_cnt_r >= TO_V) begin
            state_r <= STALLED;
            stall   <= 1'b1;
          end
        end
        STALLED: begin
          if (rise_s) begin
            state_r <= ARMED;
            stall   <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          stall   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench: a sample-level reference predicts each measurement and
// stall transition with its cycle; monitors compare as the DUT reports them.
`timescale 1ns/1ps
module tb_clk_div_monitor;

  localparam int CNT_W   = 8;
  localparam int EXP_DIV = 7;
  localparam int TIMEOUT = 200;
  localparam int CNT_W2  = 4;
  localparam int TO2     = 15;

  typedef struct { int cyc; int per; int hi; int f; int d; int e; } meas_t;
  typedef struct { int cyc; int val; } stall_t;

  logic clk, rst, div_in, div_in2;
  logic [CNT_W-1:0]  period_out, high_out;
  logic              meas_valid, freq_ok, duty_ok, stall;
  logic [7:0]        err_cnt;
  logic [CNT_W2-1:0] period_out2, high_out2;
  logic              meas_valid2, freq_ok2, duty_ok2, stall2;
  logic [7:0]        err_cnt2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int mv_cnt = 0;
  int mv2_cnt = 0;
  int mv0;

  meas_t  meas_q[$];
  stall_t stall_q[$];

  int   r_state = 0;
  logic r_prev = 1'b0;
  int   r_g = 0, r_hi = 0, r_err = 0;
  logic prev_stall = 1'b0;

  clk_div_monitor #(.CNT_W(CNT_W), .EXP_DIV(EXP_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .div_in(div_in),
    .period_out(period_out), .high_out(high_out), .meas_valid(meas_valid),
    .freq_ok(freq_ok), .duty_ok(duty_ok), .stall(stall), .err_cnt(err_cnt));

  clk_div_monitor #(.CNT_W(CNT_W2), .EXP_DIV(EXP_DIV), .TIMEOUT(TO2)) dut2 (
    .clk(clk), .rst(rst), .div_in(div_in2),
    .period_out(period_out2), .high_out(high_out2), .meas_valid(meas_valid2),
    .freq_ok(freq_ok2), .duty_ok(duty_ok2), .stall(stall2), .err_cnt(err_cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Reference: watches raw div_in at each posedge; DUT reacts two cycles later.
  always @(posedge clk) begin
    meas_t  m;
    stall_t s;
    int     diff;
    cyc = cyc + 1;
    if (!rst) begin
      r_state = 0; r_prev = 1'b0; r_g = 0; r_hi = 0; r_err = 0;
      meas_q.delete();
      stall_q.delete();
    end else begin
      if (div_in && !r_prev) begin
        if (r_state == 1) begin
          m.cyc = cyc + 2;
          m.per = sat(r_g);
          m.hi  = sat(r_hi);
          m.f   = (m.per == EXP_DIV) ? 1 : 0;
          diff  = 2 * m.hi - m.per;
          m.d   = (diff >= -1 && diff <= 1) ? 1 : 0;
          if (!(m.f == 1 && m.d == 1) && r_err < 255) r_err++;
          m.e = r_err;
          meas_q.push_back(m);
        end else if (r_state == 2) begin
          s.cyc = cyc + 2; s.val = 0;
          stall_q.push_back(s);
        end
        r_state = 1; r_g = 1; r_hi = 1;
      end else begin
        if (r_state == 1 && r_g >= TIMEOUT) begin
          r_state = 2;
          s.cyc = cyc + 2; s.val = 1;
          stall_q.push_back(s);
        end
        r_g++;
        if (div_in) r_hi++;
      end
      r_prev = div_in;
    end
  end

  // Output monitor, sampling mid-cycle.
  always @(negedge clk) begin
    meas_t  m;
    stall_t s;
    if (meas_valid2) mv2_cnt++;
    if (!rst) begin
      prev_stall = stall;
    end else begin
      if (meas_valid) begin
        mv_cnt++;
        check_val("meas_expected", (meas_q.size() != 0) ? 1 : 0, 1);
        if (meas_q.size() != 0) begin
          m = meas_q.pop_front();
          check_val("meas_cycle", cyc, m.cyc);
          check_val("period_out", period_out, m.per);
          check_val("high_out", high_out, m.hi);
          check_val("freq_ok", freq_ok, m.f);
          check_val("duty_ok", duty_ok, m.d);
          check_val("err_cnt", err_cnt, m.e);
          check_val("stall_at_meas", stall, 0);
        end
      end
      if (stall !== prev_stall) begin
        check_val("stall_expected", (stall_q.size() != 0) ? 1 : 0, 1);
        if (stall_q.size() != 0) begin
          s = stall_q.pop_front();
          check_val("stall_cycle", cyc, s.cyc);
          check_val("stall_value", stall, s.val);
        end
      end
      prev_stall = stall;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic half_step();
    @(clk); #1;
  endtask

  task automatic drive(input int h, input int l, input int n);
    repeat (n) begin
      div_in = 1'b1; repeat (h) step();
      div_in = 1'b0; repeat (l) step();
    end
  endtask

  task automatic drive_half(input int h, input int l, input int n);
    repeat (n) begin
      div_in = 1'b1; repeat (h) half_step();
      div_in = 1'b0; repeat (l) half_step();
    end
  endtask

  task automatic drive2(input int h, input int l, input int n);
    repeat (n) begin
      div_in2 = 1'b1; repeat (h) step();
      div_in2 = 1'b0; repeat (l) step();
    end
  endtask

  initial begin
    rst = 1'b0; div_in = 1'b0; div_in2 = 1'b0;
    repeat (3) step();
    check_val("rst_period_out", period_out, 0);
    check_val("rst_high_out", high_out, 0);
    check_val("rst_meas_valid", meas_valid, 0);
    check_val("rst_freq_ok", freq_ok, 0);
    check_val("rst_duty_ok", duty_ok, 0);
    check_val("rst_stall", stall, 0);
    check_val("rst_err_cnt", err_cnt, 0);
    check_val("rst2_period_out", period_out2, 0);
    check_val("rst2_stall", stall2, 0);
    rst = 1'b1;
    repeat (3) step();

    // Nominal 4/3 waveform: first rise discarded, four measurements.
    mv0 = mv_cnt;
    drive(4, 3, 5);
    check_val("nominal_meas_count", mv_cnt - mv0, 4);

    // Odd divider output with 3.5-cycle high time.
    @(negedge clk); #1;
    drive_half(7, 7, 5);
    step();

    // Wrong ratio and duty.
    drive(5, 3, 4);
    check_val("bad_period", period_out, 8);
    check_val("bad_high", high_out, 5);
    check_val("bad_freq_ok", freq_ok, 0);
    check_val("bad_duty_ok", duty_ok, 0);

    // Stall on held-high input, then recovery.
    drive(4, 3, 3);
    div_in = 1'b1;
    repeat (250) step();
    check_val("stall_held_high", stall, 1);
    div_in = 1'b0;
    repeat (3) step();
    mv0 = mv_cnt;
    drive(4, 3, 3);
    check_val("recover_meas_count", mv_cnt - mv0, 2);
    check_val("recover_period", period_out, 7);
    check_val("recover_stall", stall, 0);

    // Asynchronous reset in the middle of a high phase.
    div_in = 1'b1;
    repeat (4) step();
    #2 rst = 1'b0;
    #1;
    check_val("mid_rst_period_out", period_out, 0);
    check_val("mid_rst_high_out", high_out, 0);
    check_val("mid_rst_freq_ok", freq_ok, 0);
    check_val("mid_rst_duty_ok", duty_ok, 0);
    check_val("mid_rst_err_cnt", err_cnt, 0);
    div_in = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    mv0 = mv_cnt;
    drive(4, 3, 4);
    repeat (3) step();
    check_val("post_rst_meas_count", mv_cnt - mv0, 3);

    // Narrow counters: 20-cycle period always times out.
    drive2(10, 10, 3);
    check_val("narrow_meas_count", mv2_cnt, 0);
    check_val("narrow_stall", stall2, 1);
    check_val("narrow_err_cnt", err_cnt2, 0);
    check_val("narrow_period_out", period_out2, 0);

    // Period equal to the timeout: rise wins and is measured.
    drive2(8, 7, 2);
    div_in2 = 1'b1;
    repeat (4) step();
    div_in2 = 1'b0;
    check_val("edge_meas_count", mv2_cnt, 2);
    check_val("edge_period_out", period_out2, 15);
    check_val("edge_high_out", high_out2, 8);
    check_val("edge_freq_ok", freq_ok2, 0);
    check_val("edge_duty_ok", duty_ok2, 1);
    check_val("edge_err_cnt", err_cnt2, 2);
    check_val("edge_stall", stall2, 0);

    // Let the idle main input time out, then drain the scoreboard.
    repeat (260) step();
    check_val("final_stall", stall, 1);
    check_val("meas_q_left", meas_q.size(), 0);
    check_val("stall_q_left", stall_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Measurement stage that sits directly downstream of the odd/even clock dividers and consumes their divided-clock output. It samples the divided clock in the source clock domain and measures its period and high time in source-clock cycles. It flags the result against an expected divide ratio and a 50 % duty tolerance, and raises a stall flag when the divided clock stops toggling. It is used for on-chip self-check of the divider chain and as a bench-side checker.

## Interface
- CNT_W, 8: width of the period and high-time counters and outputs.
- EXP_DIV, 7: expected divide ratio, in source-clock cycles per divided period.
- TIMEOUT, 200: number of cycles without a rise before stall asserts; must be at least 2*EXP_DIV and at most 2^CNT_W-1.
- clk  input  1  source clock, the same clock that drives the divider; all logic is on posedge.
- rst  input  1  asynchronous active-low reset.
- div_in  input  1  divided clock under test; treated as asynchronous because it may change on negedge.
- period_out  output  CNT_W  last measured period in clk cycles.
- high_out  output  CNT_W  last measured count of posedge samples where div_in was high.
- meas_valid  output  1  one-cycle pulse when period_out and high_out update.
- freq_ok  output  1  period_out == EXP_DIV; valid from the first meas_valid.
- duty_ok  output  1  |2*high_out - period_out| <= 1, computed at CNT_W+1 bits.
- stall  output  1  no rise seen for TIMEOUT cycles.
- err_cnt  output  8  count of measurements with freq_ok=0 or duty_ok=0; saturates at 255.

## Operation
- Synchronizer: div_in passes through s1 and s2, then through s3 for edge detection. rise = s2 & ~s3.
- period_cnt:
  - Set to 1 on rise.
  - Otherwise increments, saturating at 2^CNT_W-1.
- high_cnt:
  - Set to 1 on rise, since s2=1 on that cycle.
  - Otherwise adds s2, saturating at 2^CNT_W-1.
- States (2-bit FSM):
  - IDLE: after reset. On the first rise, go to ARMED. The first partial period is discarded, and no meas_valid is produced.
  - ARMED, on rise: latch period_out <= period_cnt and high_out <= high_cnt, pulse meas_valid, update freq_ok/duty_ok/err_cnt. Stay in ARMED.
  - ARMED, when period_cnt reaches TIMEOUT without a rise: go to STALLED and set stall=1.
  - STALLED, on rise: clear stall and go to ARMED. The interrupted measurement is discarded: no meas_valid, and outputs hold their old values.
- freq_ok, duty_ok and err_cnt update in the same cycle as period_out. err_cnt increments at most once per measurement.
- A constant-high or constant-low div_in behaves the same: both lead to stall.
- Reset mid-measurement: all state clears immediately and the FSM returns to IDLE. The next rise is discarded again.

## Timing
- Reset values: period_out=0, high_out=0, meas_valid=0, freq_ok=0, duty_ok=0, stall=0, err_cnt=0, FSM=IDLE, synchronizer flops=0.
- Latency: if div_in rises before posedge k, s1=1 after k and rise is true during cycle k+1..k+2. Outputs update at posedge k+2, and meas_valid is high for the one cycle after k+2.
- meas_valid spacing equals the measured period. The minimum legal period is 2 (div_in toggling every cycle), which gives period_out=2 and high_out=1.
- stall asserts at the posedge where period_cnt would reach TIMEOUT, i.e. TIMEOUT cycles after the last rise. It deasserts at the posedge that latches the next rise.
- Rise coinciding with the TIMEOUT cycle: rise wins. The measurement is latched and stall stays 0.
- Metastability: s1 is the only flop that samples div_in. A ±1-cycle jitter on a posedge-misaligned edge is accepted and covered by the duty tolerance.

## Test plan
- Drive div_in 4 cycles high / 3 low, posedge-aligned, for 5 periods -> 4 meas_valid pulses (the first rise is discarded); period_out=7, high_out=4, freq_ok=1, duty_ok=1, err_cnt=0.
- Connect the 7-way odd divider output (high 3.5 cycles) -> period_out=7, high_out=3 or 4 constant across periods, freq_ok=1, duty_ok=1.
- Drive div_in 5 high / 3 low with EXP_DIV=7 for 3 measured periods -> period_out=8, high_out=5, freq_ok=0, duty_ok=0, err_cnt=3.
- Stop div_in (held high) after 3 periods -> stall=1 exactly TIMEOUT=200 cycles after the last rise. Resume toggling -> stall=0 at the first rise, no meas_valid for that rise, next meas_valid period_out=7.
- Deassert rst mid-period, then reassert -> all outputs 0 immediately. The first rise after release yields no meas_valid; the second rise does.
- Set CNT_W=4 and TIMEOUT=15, and drive a 20-cycle period -> period_cnt saturates at 15, stall asserts and no measurement is reported; err_cnt unchanged.
